// File: rtl/comp_pkg.sv
`default_nettype none
// comp_pkg: shared state encoding and sizing constants for the bit packer.
// Rev 1.0
package comp_pkg;

    typedef enum logic [1:0] {
        PACK  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ACC_W  = 48;
    localparam int WORD_W = 32;
    localparam int CODE_W = 16;
    localparam int LEN_W  = 5;
    localparam int CNT_W  = 6;

endpackage
`default_nettype wire

// File: rtl/comp_bit_merge.sv
`default_nettype none
// comp_bit_merge: masks a code to its clipped length and appends it below the
// occupied bits of the MSB-aligned accumulator. Rev 1.0
module comp_bit_merge #(
    parameter int CODE_W = 16
) (
    input  logic [comp_pkg::ACC_W-1:0] acc,
    input  logic [comp_pkg::CNT_W-1:0] bit_cnt,
    input  logic [CODE_W-1:0]          code,
    input  logic [comp_pkg::LEN_W-1:0] len,
    output logic [comp_pkg::ACC_W-1:0] acc_next,
    output logic [comp_pkg::CNT_W-1:0] cnt_next
);
    import comp_pkg::*;

    logic [LEN_W-1:0]  len_clip;
    logic [CODE_W-1:0] masked;
    logic [CNT_W-1:0]  shift;

    always_comb begin
        len_clip = (len > 5'd16) ? 5'd16 : len;
        // Shifting all-ones by the full width yields zero, so len 16 keeps every bit.
        masked   = code & ~({CODE_W{1'b1}} << len_clip);
        shift    = CNT_W'(ACC_W) - bit_cnt - {1'b0, len_clip};
        acc_next = acc | ({{(ACC_W-CODE_W){1'b0}}, masked} << shift);
        cnt_next = bit_cnt + {1'b0, len_clip};
    end

endmodule
`default_nettype wire

// File: rtl/comp_bit_packer.sv
`default_nettype none
// comp_bit_packer: packs variable-length codes into MSB-first words with flush.
// Optional COMP_PACKER_CNT_EN adds a per-image word_count output. Rev 1.0
module comp_bit_packer #(
    parameter int WORD_W = 32,
    parameter int CODE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [4:0]        in_len,
    input  logic              in_last,
    input  logic              full,
    output logic              wr_en,
    output logic [WORD_W-1:0] data_out,
    output logic              done
`ifdef COMP_PACKER_CNT_EN
    ,
    output logic [11:0]       word_count
`endif
);
    import comp_pkg::*;

    state_t             state, state_next;
    logic [ACC_W-1:0]   acc, acc_next, merged_acc;
    logic [CNT_W-1:0]   bit_cnt, cnt_next, merged_cnt;
    logic               handshake, emit_word, emit_tail;

    comp_bit_merge #(.CODE_W(CODE_W)) u_merge (
        .acc      (acc),
        .bit_cnt  (bit_cnt),
        .code     (in_code),
        .len      (in_len),
        .acc_next (merged_acc),
        .cnt_next (merged_cnt)
    );

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = bit_cnt;
        in_ready   = (state == PACK) && (bit_cnt < CNT_W'(WORD_W));
        handshake  = in_valid && in_ready;
        emit_word  = bit_cnt >= CNT_W'(WORD_W);
        emit_tail  = (state == FLUSH) && (bit_cnt != '0) && !emit_word;
        wr_en      = !full && (emit_word || emit_tail);
        data_out   = acc[ACC_W-1 -: WORD_W];
        done       = (state == DONE);

        // Handshake and emit are mutually exclusive because in_ready needs bit_cnt < WORD_W.
        if (wr_en) begin
            if (emit_word) begin
                acc_next = acc << WORD_W;
                cnt_next = bit_cnt - CNT_W'(WORD_W);
            end else begin
                acc_next = '0;
                cnt_next = '0;
            end
        end else if (handshake) begin
            acc_next = merged_acc;
            cnt_next = merged_cnt;
        end

        case (state)
            PACK:    if (handshake && in_last) state_next = FLUSH;
            FLUSH:   if (bit_cnt == '0) state_next = DONE;
            DONE:    state_next = PACK;
            default: state_next = PACK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= PACK;
            acc     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            bit_cnt <= cnt_next;
        end
    end

`ifdef COMP_PACKER_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count <= '0;
        end else if (done) begin
            word_count <= '0;
        end else if (wr_en && (word_count != 12'hFFF)) begin
            word_count <= word_count + 12'd1;
        end
    end
`endif

endmodule
`default_nettype wire
